// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Single-outstanding-request instruction fetch stage. Issues word requests to
//   instruction memory, holds the fetched word until downstream accepts it, and
//   handles taken-branch redirects, including redirects that land while a
//   request is still in flight (the stale response is drained and discarded).
//
//   Optional feature macro: INSTR_FETCH_MISALIGN_CHECK_EN
//     defined   : a fetch launched from a non-word-aligned pc parks the unit in
//                 FAULT, presenting a NOP tagged with the bad pc and raising
//                 fetch_misaligned until the next redirect or reset.
//     undefined : pc/req_addr low bits are forced to zero on every load, FAULT
//                 is unreachable and fetch_misaligned stays 0.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   imem_req/addr     : memory request valid / word address (held until ack)
//   imem_ack/rdata    : memory response strobe / returned word
//   instr/instr_pc    : fetched instruction and its address
//   instr_valid       : instr/instr_pc valid
//   instr_ready       : downstream accepts instr this cycle
//   redirect/_pc      : branch/jump taken and its target
//   fetch_misaligned  : misaligned-target fault flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misaligned
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC;
`else
    localparam logic [XLEN-1:0] RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DROP,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] redirect_tgt;

    // Launch of a new fetch, decided by the next-state logic
    logic            launch;
    logic [XLEN-1:0] launch_addr;
    logic            launch_fault;

    // Next values of the datapath / output registers
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_addr_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] instr_pc_d;
    logic            valid_d;
    logic            fault_d;
    logic            req_d;

    // Redirect target as loaded into pc (low bits dropped when not checking)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    assign imem_addr = req_addr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; redirect outranks every other event
    always_comb begin
        next_state   = state;
        launch       = 1'b0;
        launch_addr  = pc;
        launch_fault = 1'b0;
        case (state)
            S_IDLE: begin
                launch      = 1'b1;
                launch_addr = redirect ? redirect_tgt : pc;
            end
            S_FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        launch      = 1'b1;
                        launch_addr = redirect_tgt;
                    end else begin
                        next_state = S_DROP;
                    end
                end else if (imem_ack) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    launch      = 1'b1;
                    launch_addr = redirect_tgt;
                end else if (instr_ready) begin
                    launch      = 1'b1;
                    launch_addr = pc;
                end
            end
            S_DROP: begin
                // Stale response drained; restart from the newest target
                if (imem_ack) begin
                    launch      = 1'b1;
                    launch_addr = redirect ? redirect_tgt : pc;
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    launch      = 1'b1;
                    launch_addr = redirect_tgt;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        launch_fault = launch && (launch_addr[1:0] != 2'b00);
`endif
        if (launch) begin
            next_state = launch_fault ? S_FAULT : S_FETCH;
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        pc_d       = pc;
        req_addr_d = req_addr;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        valid_d    = instr_valid;
        fault_d    = fetch_misaligned;
        req_d      = (next_state == S_FETCH) || (next_state == S_DROP);

        if (redirect) begin
            pc_d    = redirect_tgt;
            valid_d = 1'b0;
        end else if ((state == S_FETCH) && imem_ack) begin
            instr_d    = imem_rdata;
            instr_pc_d = req_addr;
            valid_d    = 1'b1;
            pc_d       = pc + PC_STEP;
        end else if ((state == S_HOLD) && instr_ready) begin
            valid_d = 1'b0;
        end

        if (launch) begin
            pc_d       = launch_addr;
            req_addr_d = launch_addr;
            valid_d    = 1'b0;
            fault_d    = 1'b0;
            if (launch_fault) begin
                valid_d    = 1'b1;
                instr_d    = NOP;
                instr_pc_d = launch_addr;
                fault_d    = 1'b1;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc               <= RESET_ADDR;
            req_addr         <= RESET_ADDR;
            instr            <= NOP;
            instr_pc         <= '0;
            instr_valid      <= 1'b0;
            fetch_misaligned <= 1'b0;
            imem_req         <= 1'b0;
        end else begin
            pc               <= pc_d;
            req_addr         <= req_addr_d;
            instr            <= instr_d;
            instr_pc         <= instr_pc_d;
            instr_valid      <= valid_d;
            fetch_misaligned <= fault_d;
            imem_req         <= req_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory request valid.
REQ-005 SHALL have port imem_addr, output, 32 bits: request word address.
REQ-006 SHALL have port imem_ack, input, 1 bit: memory returns imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched word.
REQ-008 SHALL have port instr, output, 32 bits: fetched instruction fed to the control extractor.
REQ-009 SHALL have port instr_pc, output, 32 bits: address of instr.
REQ-010 SHALL have port instr_valid, output, 1 bit: instr/instr_pc valid.
REQ-011 SHALL have port instr_ready, input, 1 bit: downstream accepts instr this cycle.
REQ-012 SHALL have port redirect, input, 1 bit: branch/jump taken.
REQ-013 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-014 SHALL have port fetch_misaligned, output, 1 bit: misaligned-target fault flag.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD, DROP, FAULT, with one outstanding memory request at most.
REQ-016 SHALL drive imem_req=1 only in FETCH and DROP; imem_addr from a req_addr register, stable while imem_req=1 and imem_ack=0.
REQ-017 IDLE SHALL go to FETCH unconditionally, with req_addr<=pc; first request is visible the cycle after reset release.
REQ-018 FETCH with imem_ack SHALL capture instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1, pc<=pc+4 (mod 2^32), then go to HOLD; imem_rdata is not required to be stable afterwards.
REQ-019 HOLD SHALL keep instr/instr_pc/instr_valid stable until instr_ready=1, then clear instr_valid, set req_addr<=pc, and go to FETCH.
REQ-020 redirect SHALL have highest priority in every state: pc<=redirect_pc, instr_valid<=0, and no instruction from the old path is presented.
REQ-021 redirect in FETCH without imem_ack SHALL go to DROP; in FETCH with imem_ack same cycle, the data SHALL be discarded and the unit goes to FETCH at redirect_pc; in HOLD or FETCH-with-ack, go to FETCH with req_addr<=redirect_pc.
REQ-022 DROP SHALL hold the old req_addr request until imem_ack, discard the data, then go to FETCH with req_addr<=pc; further redirects in DROP update pc only.
REQ-023 redirect concurrent with instr_ready in HOLD SHALL count as accepted; the redirect target is fetched next.
REQ-024 fetch_misaligned SHALL be 0 except as stated in REQ-029.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE, pc=RESET_PC, req_addr=RESET_PC, instr=32'h0000_0013, instr_pc=0, instr_valid=0, fetch_misaligned=0, imem_req=0.
REQ-026 reset mid-request SHALL abandon the request; an imem_ack arriving while in IDLE SHALL be ignored.

Configuration
REQ-027 Macro INSTR_FETCH_MISALIGN_CHECK_EN SHALL select misaligned-target handling.
REQ-028 Without the macro, pc[1:0] and req_addr[1:0] SHALL be forced to 0 on every load; FAULT is unreachable; fetch_misaligned is tied to 0.
REQ-029 With the macro, launching a fetch with pc[1:0]!=0 SHALL enter FAULT instead of FETCH: imem_req=0, instr_valid=1, instr=32'h0000_0013, instr_pc=pc, fetch_misaligned=1; only redirect or reset leaves FAULT, and instr_ready is ignored.

Verification
REQ-030 Reset release, RESET_PC=0x100, 1-cycle ack of 0x00500093, instr_ready=1 -> imem_addr=0x100 at cycle 1, instr=0x00500093/instr_pc=0x100 valid, next imem_addr=0x104.
REQ-031 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, no pc advance.
REQ-032 redirect to 0x200 while 0x104 is outstanding (ack 3 cycles later) -> imem_addr stays 0x104 until ack, data dropped, next request 0x200, first valid instr_pc=0x200.
REQ-033 redirect same cycle as imem_ack -> data discarded, next request at target, instr_valid never shows the old word.
REQ-034 pc=0xFFFF_FFFC fetch -> next request 0x0000_0000.
REQ-035 redirect_pc=0x202 -> with macro: FAULT, fetch_misaligned=1, no imem_req until a redirect to 0x300; without macro: request 0x200.
